// File: rtl/axi_mcast_b_join.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_mcast_b_join: collects one B beat per destination of a multicast write
// and returns a single merged B to the issuing slave port.   Revision: 1.0
// ----------------------------------------------------------------------------
module axi_mcast_b_join #(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned MaxTrans   = 8,
  parameter int unsigned IdWidth    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [NoMstPorts-1:0]     cmd_select_i,
  input  logic [IdWidth-1:0]        cmd_id_i,
  input  logic [NoMstPorts-1:0]     mst_b_valid_i,
  output logic [NoMstPorts-1:0]     mst_b_ready_o,
  input  logic [2*NoMstPorts-1:0]   mst_b_resp_i,
  output logic                      slv_b_valid_o,
  input  logic                      slv_b_ready_i,
  output logic [IdWidth-1:0]        slv_b_id_o,
  output logic [1:0]                slv_b_resp_o
);

  localparam int unsigned PTR_W = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CNT_W = $clog2(MaxTrans + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MaxTrans - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MaxTrans);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Severity order DECERR > SLVERR > OKAY > EXOKAY makes the merge a max().
  function automatic logic [1:0] resp_rank(input logic [1:0] r);
    logic [1:0] rank;
    case (r)
      RESP_DECERR: rank = 2'd3;
      RESP_SLVERR: rank = 2'd2;
      RESP_OKAY:   rank = 2'd1;
      default:     rank = 2'd0;
    endcase
    return rank;
  endfunction

  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (resp_rank(b) > resp_rank(a)) ? b : a;
  endfunction

  logic [NoMstPorts-1:0] sel_mem [MaxTrans];
  logic [IdWidth-1:0]    id_mem  [MaxTrans];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [NoMstPorts-1:0] acc_mask_q, acc_mask_d;
  logic [1:0]            acc_resp_q, acc_resp_d;
  logic                  slv_valid_q, slv_valid_d;
  logic [IdWidth-1:0]    slv_id_q, slv_id_d;
  logic [1:0]            slv_resp_q, slv_resp_d;

  logic                  head_valid, collect, complete, push, pop;
  logic [NoMstPorts-1:0] head_sel, b_ready, b_hs;
  logic [IdWidth-1:0]    head_id;
  logic [1:0]            merged_acc, final_resp;

  always_comb begin
    head_valid = (count_q != '0);
    head_sel   = sel_mem[rd_ptr_q];
    head_id    = id_mem[rd_ptr_q];
    // Collection pauses while a merged B waits, so the output never gets overwritten.
    collect    = head_valid & ~slv_valid_q;
    b_ready    = collect ? (head_sel & ~acc_mask_q) : '0;
    b_hs       = mst_b_valid_i & b_ready;

    merged_acc = acc_resp_q;
    for (int unsigned j = 0; j < NoMstPorts; j++) begin
      if (b_hs[j]) merged_acc = resp_merge(merged_acc, mst_b_resp_i[2*j +: 2]);
    end
    final_resp = (head_sel == '0) ? RESP_OKAY : merged_acc;

    complete = collect & ((acc_mask_q | b_hs) == head_sel);
    push     = cmd_valid_i & cmd_ready_q;
    pop      = complete;

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != FULL_CNT);

    acc_mask_d  = acc_mask_q | b_hs;
    acc_resp_d  = merged_acc;
    slv_valid_d = slv_valid_q & ~slv_b_ready_i;
    slv_id_d    = slv_id_q;
    slv_resp_d  = slv_resp_q;
    if (complete) begin
      acc_mask_d  = '0;
      acc_resp_d  = RESP_EXOKAY;
      slv_valid_d = 1'b1;
      slv_id_d    = head_id;
      slv_resp_d  = final_resp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      sel_mem[wr_ptr_q] <= cmd_select_i;
      id_mem[wr_ptr_q]  <= cmd_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      acc_mask_q  <= '0;
      acc_resp_q  <= RESP_EXOKAY;
      slv_valid_q <= 1'b0;
      slv_id_q    <= '0;
      slv_resp_q  <= RESP_OKAY;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      acc_mask_q  <= acc_mask_d;
      acc_resp_q  <= acc_resp_d;
      slv_valid_q <= slv_valid_d;
      slv_id_q    <= slv_id_d;
      slv_resp_q  <= slv_resp_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign mst_b_ready_o = b_ready;
  assign slv_b_valid_o = slv_valid_q;
  assign slv_b_id_o    = slv_id_q;
  assign slv_b_resp_o  = slv_resp_q;

`ifndef SYNTHESIS
  a_no_early_b: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (!head_valid && !push) |-> ((mst_b_valid_i & ~$past(mst_b_valid_i)) == '0))
    else $error("B valid raised with no outstanding command");
  a_slv_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_valid_q && !slv_b_ready_i) |=> (slv_valid_q && $stable(slv_id_q) && $stable(slv_resp_q)))
    else $error("merged B changed while stalled");
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q <= FULL_CNT) && !(push && count_q == FULL_CNT))
    else $error("command FIFO overflow");
  a_zero_select: assert property (@(posedge clk_i) disable iff (!rst_ni)
    head_valid |-> (head_sel != '0))
    else $error("command with empty destination set");
`endif

endmodule
`default_nettype wire

// File: doc/axi_mcast_b_join.md
Name: axi_mcast_b_join

Overview:
- Response-side counterpart of the multicast write fan-out in the multicast crossbar slave-port demux.
- A multicast AW is forwarded to a set of master ports, and each port returns its own B beat.
- This block records each write's destination set, collects exactly one B per selected port, merges the response codes and returns a single B to the issuing slave port.
- Instantiated once per slave port, between the demux B inputs and the slave-port B channel.

Parameters:
- NoMstPorts, 4, number of B sources (master ports including the decode-error slave); must be >= 1.
- MaxTrans, 8, depth of the outstanding-command FIFO; any value >= 1.
- IdWidth, 4, width of the slave-side AXI ID.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  AW-handshake notification from the demux: a write was issued.
- cmd_ready_o  out  1  command FIFO can accept.
- cmd_select_i  in  NoMstPorts  one-hot/multi-hot destination set of the write.
- cmd_id_i  in  IdWidth  slave-side AW ID.
- mst_b_valid_i  in  NoMstPorts  per-port B valid.
- mst_b_ready_o  out  NoMstPorts  per-port B ready.
- mst_b_resp_i  in  2*NoMstPorts  per-port BRESP; port j occupies bits [2j+1:2j].
- slv_b_valid_o  out  1  merged B valid.
- slv_b_ready_i  in  1  merged B ready.
- slv_b_id_o  out  IdWidth  merged B ID, taken from the command.
- slv_b_resp_o  out  2  merged BRESP.

Behaviour:
- Reset (async, rst_ni=0):
  - FIFO empty; head accepted-mask = 0; resp accumulator = EXOKAY marker.
  - slv_b_valid_o=0, slv_b_id_o=0, slv_b_resp_o=0.
  - cmd_ready_o=0 while in reset, 1 after reset when not full.
  - mst_b_ready_o=0.
  - Reset mid-transaction discards all pending commands and partial collections.
- Command FIFO:
  - Entries are {select, id}; push on cmd_valid_i & cmd_ready_o.
  - cmd_ready_o = !full, registered-count based. No same-cycle push-through when full, even if a pop occurs.
  - Occupancy counter ranges 0..MaxTrans; read/write pointers wrap modulo MaxTrans.
- Collection (head entry present, output register empty):
  - mst_b_ready_o[j] = head_select[j] & ~acc_mask[j] & ~slv_b_valid_o.
  - A handshake on port j sets acc_mask[j] and merges mst_b_resp_i[j] into the accumulator.
  - Multiple ports may handshake in the same cycle; all are merged.
  - Ports outside head_select, or already collected, see ready=0. A second beat from the same port waits for a later command.
- Merge rule (order-independent):
  - Result is DECERR(11) if any beat is DECERR.
  - Else SLVERR(10) if any beat is SLVERR.
  - Else OKAY(00) if any beat is OKAY.
  - Else EXOKAY(01), i.e. all beats were EXOKAY.
- Completion:
  - Condition: (acc_mask | this-cycle handshakes) == head_select.
  - On the next edge: load slv_b_valid_o=1, slv_b_id_o=head id, slv_b_resp_o=merged value; pop FIFO; clear acc_mask and accumulator.
  - Latency: merged B valid exactly 1 cycle after the last contributing handshake.
- Zero select: a head entry with select==0 completes immediately and yields OKAY one cycle after reaching the head. Flagged by a simulation assertion as illegal usage.
- Output: slv_b_* held stable while slv_b_valid_o & ~slv_b_ready_i. Valid drops on handshake unless a new completion loads in the same edge.
  - Collection for the next head stalls while the output is occupied, so a new completion cannot load while the previous B is unaccepted.
  - Back-to-back throughput: one merged B per 2 cycles minimum.
- Assertions:
  - no mst_b_valid_i rising on a port while the FIFO is empty, unless it is held to a later command;
  - valid/payload stability on slv_b while stalled;
  - no FIFO overflow.

Test Plan:
- Unicast: cmd select=0001, id=3; port0 B OKAY at cycle t -> slv_b valid at t+1, id=3, resp=00; FIFO empty afterwards.
- Multicast merge: select=1011; ports 0,1 EXOKAY same cycle, port3 SLVERR 5 cycles later -> single B resp=10, emitted one cycle after port3 handshake; port2 ready never asserted.
- All-EXOKAY: select=0110, both EXOKAY -> resp=01. Repeat with one OKAY -> resp=00. DECERR + SLVERR -> 11.
- Full/backpressure: push 8 commands (MaxTrans=8) with slv_b_ready_i=0 -> cmd_ready_o=0 after 8th push; release ready -> 8 B beats in command order with matching ids; cmd_ready_o returns 1 the cycle after first pop.
- Ordering: commands A(select 0011), B(select 0001); port0 presents its second beat early -> it stays unaccepted until A completes and B is head, then B completes with its own resp.
- Reset mid-op: 2 commands pending, 1 beat collected, assert rst_ni=0 for 1 cycle -> all outputs 0, FIFO empty, no stale B emitted afterwards.
